eeprom_master: RTL and testbench

Microwire (93C46/93C66-style) EEPROM initiator: accepts single-word READ, WRITE, EWEN and EWDS commands on a valid/ready port and generates the serial frames on `eesk`/`eecs`/`eedi`. It samples the response on `eedo`. It drives the same four-wire interface that `eeprom_emu` responds to. It sits in the NIC clock domain and lets control logic load or update configuration words without host involvement.

---
 rtl/eeprom_master.sv | 235 +++++++++++++++++++++++
 tb/tb_eeprom_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_master.sv
// eeprom_master: Microwire (93C46/93C66-style) EEPROM initiator.
// Takes single READ / WRITE / EWEN / EWDS commands on a valid/ready port,
// shifts the serial frame out on eesk/eecs/eedi and samples eedo. After a
// WRITE it polls eedo for the ready indication, bounded by POLL_TIMEOUT.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only in IDLE)
//   cmd_op_i                0 READ, 1 WRITE, 2 EWEN, 3 EWDS
//   cmd_addr_i, cmd_wdata_i word address and write data
//   rsp_valid_o             one-cycle completion pulse
//   rsp_data_o              read data, held until the next READ completes
//   rsp_err_o               READ: dummy bit not 0; WRITE: poll timeout
//   busy_o                  inverse of cmd_ready_o
//   eesk_o/eecs_o/eedi_o    serial clock, chip select, data to EEPROM
//   eedo_i                  data from EEPROM (already synchronous)
module eeprom_master #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned POLL_TIMEOUT = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [ADDR_BITS-1:0] cmd_addr_i,
  input  logic [15:0]          cmd_wdata_i,
  output logic                 rsp_valid_o,
  output logic [15:0]          rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic                 eesk_o,
  output logic                 eecs_o,
  output logic                 eedi_o,
  input  logic                 eedo_i
);

  localparam int unsigned FRAME_W = ADDR_BITS + 19;
  localparam int unsigned CW      = $clog2(2 * CLK_DIV);
  localparam int unsigned BW      = $clog2(FRAME_W);
  localparam int unsigned PW      = $clog2(POLL_TIMEOUT + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] DUMMY_BIT = BW'(ADDR_BITS + 2);   // last address bit
  localparam logic [BW-1:0] LONG_LAST = BW'(FRAME_W - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CS_GAP, S_POLL, S_CS_GAP2, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ = 2'd0, OP_WRITE = 2'd1, OP_EWEN = 2'd2, OP_EWDS = 2'd3
  } op_e;

  state_e               state_q;
  op_e                  op_q;
  op_e                  cmd_op;
  logic [CW-1:0]        div_q;
  logic [BW-1:0]        bit_q;
  logic [BW-1:0]        last_q;
  logic [FRAME_W-1:0]   sreg_q;
  logic [PW-1:0]        poll_q;
  logic [15:0]          rdata_q;
  logic                 err_q;
  logic                 rsp_valid_q;
  logic [15:0]          rsp_data_q;
  logic                 rsp_err_q;
  logic                 eesk_q;
  logic                 eecs_q;
  logic                 eedi_q;

  logic [1:0]           opc_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [15:0]          data_d;
  logic [FRAME_W-1:0]   frame_d;

  assign cmd_op = op_e'(cmd_op_i);

  // Whole frame is built at acceptance and shifted out MSB first. READ
  // carries a zero data field so eedi stays low while the word comes back.
  always_comb begin
    opc_d  = 2'b00;
    addr_d = cmd_addr_i;
    data_d = '0;
    case (cmd_op)
      OP_READ:  opc_d = 2'b10;
      OP_WRITE: begin
        opc_d  = 2'b01;
        data_d = cmd_wdata_i;
      end
      OP_EWEN: begin
        addr_d = '0;
        addr_d[ADDR_BITS-1 -: 2] = 2'b11;
      end
      default:  addr_d = '0;
    endcase
    frame_d = {1'b1, opc_d, addr_d, data_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      div_q       <= '0;
      bit_q       <= '0;
      last_q      <= '0;
      sreg_q      <= '0;
      poll_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eesk_q      <= 1'b0;
      eecs_q      <= 1'b0;
      eedi_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= cmd_op;
            sreg_q  <= frame_d;
            eecs_q  <= 1'b1;
            eesk_q  <= 1'b0;
            eedi_q  <= frame_d[FRAME_W-1];
            div_q   <= '0;
            bit_q   <= '0;
            last_q  <= cmd_op_i[1] ? DUMMY_BIT : LONG_LAST;
            err_q   <= 1'b0;
            state_q <= S_SHIFT;
          end
        end

        // eesk_q doubles as the phase flag: 0 = low half, 1 = high half.
        S_SHIFT: begin
          if (div_q == HALF_LAST) begin
            div_q <= '0;
            if (!eesk_q) begin
              eesk_q <= 1'b1;
            end else begin
              if (op_q == OP_READ) begin
                if (bit_q == DUMMY_BIT) begin
                  err_q <= eedo_i;
                end else if (bit_q > DUMMY_BIT) begin
                  rdata_q <= {rdata_q[14:0], eedo_i};
                end
              end
              eesk_q <= 1'b0;
              if (bit_q == last_q) begin
                eecs_q  <= 1'b0;
                eedi_q  <= 1'b0;
                state_q <= S_CS_GAP;
              end else begin
                bit_q  <= bit_q + 1'b1;
                sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
                eedi_q <= sreg_q[FRAME_W-2];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_CS_GAP: begin
          if (div_q == GAP_LAST) begin
            div_q <= '0;
            if (op_q == OP_WRITE) begin
              eecs_q  <= 1'b1;
              poll_q  <= '0;
              state_q <= S_POLL;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_q;
              if (op_q == OP_READ) begin
                rsp_data_q <= rdata_q;
              end
              state_q <= S_DONE;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        // A ready sample wins over a timeout landing on the same cycle.
        S_POLL: begin
          poll_q <= poll_q + 1'b1;
          div_q  <= (div_q == HALF_LAST) ? '0 : div_q + 1'b1;
          if (div_q == HALF_LAST && eedo_i) begin
            err_q   <= 1'b0;
            eecs_q  <= 1'b0;
            div_q   <= '0;
            state_q <= S_CS_GAP2;
          end else if (poll_q == POLL_LAST) begin
            err_q   <= 1'b1;
            eecs_q  <= 1'b0;
            div_q   <= '0;
            state_q <= S_CS_GAP2;
          end
        end

        S_CS_GAP2: begin
          if (div_q == GAP_LAST) begin
            div_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            state_q     <= S_DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_DONE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign eesk_o      = eesk_q;
  assign eecs_o      = eecs_q;
  assign eedi_o      = eedi_q;

endmodule

// File: tb/tb_eeprom_master.sv
// Testbench for eeprom_master: a behavioural Microwire EEPROM model answers
// the DUT, and a scoreboard of expected responses is checked against each
// rsp_valid_o pulse (data, error flag and timing).
module tb_eeprom_master;

  localparam int unsigned AB  = 8;
  localparam int unsigned C   = 4;
  localparam int unsigned PTO = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        eesk, eecs, eedi;
  logic        eedo = 1'b0;

  always #5 clk = ~clk;

  eeprom_master #(.ADDR_BITS(AB), .CLK_DIV(C), .POLL_TIMEOUT(PTO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .eesk_o      (eesk),
    .eecs_o      (eecs),
    .eedi_o      (eedi),
    .eedo_i      (eedo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // poll_mode=0: val is the rsp_valid cycle counted from acceptance.
  // poll_mode=1: val is the POLL length (eecs high) in cycles.
  typedef struct {
    logic [15:0] data;
    logic        err;
    bit          poll_mode;
    int          val;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && !rst) begin
      acc_cyc <= cyc;
      n_acc   <= n_acc + 1;
    end
  end

  // ---------------- Microwire EEPROM model ----------------
  logic [15:0] mem [256];
  bit          we = 0;
  bit          wr_busy = 0;
  int          r = 0;
  int          pcnt = 0;
  int          poll_delay = 300;
  logic        dummy_val = 1'b0;
  logic [63:0] bits = '0;
  logic [10:0] hdr = '0;
  logic        cs_prev = 1'b0, sk_prev = 1'b0;
  int          frm_sk = 0;
  logic [63:0] frm_bits = '0;

  always @(negedge clk) begin
    if (eecs && !cs_prev) begin
      if (!wr_busy) begin
        r    = 0;
        bits = '0;
      end
      pcnt = 0;
    end else if (eecs && wr_busy) begin
      pcnt++;
    end
    if (eecs && !wr_busy && eesk && !sk_prev) begin
      r++;
      bits = {bits[62:0], eedi};
      if (r == 3 + AB) hdr = bits[10:0];
    end
    if (!eecs && cs_prev) begin
      if (wr_busy) begin
        wr_busy = 0;
      end else begin
        frm_sk   = r;
        frm_bits = bits;
        if (r == 19 + AB && bits[25:24] == 2'b01) begin
          if (we) mem[bits[23:16]] = bits[15:0];
          wr_busy = 1;
        end else if (r == 3 + AB && bits[9:8] == 2'b00) begin
          we = (bits[7:6] == 2'b11);
        end
      end
    end
    if (eecs && wr_busy)
      eedo = (pcnt >= poll_delay);
    else if (eecs && hdr[9:8] == 2'b10 && r == 3 + AB)
      eedo = dummy_val;
    else if (eecs && hdr[9:8] == 2'b10 && r >= 4 + AB && r <= 19 + AB)
      eedo = mem[hdr[7:0]][19 + AB - r];
    else
      eedo = 1'b0;
    cs_prev = eecs;
    sk_prev = eesk;
  end

  // ---------------- Response monitor / scoreboard ----------------
  int   cs_rise_cyc = 0, cs_fall_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  logic mon_cs = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (eecs && !mon_cs) cs_rise_cyc = cyc;
    if (!eecs && mon_cs) cs_fall_cyc = cyc;
    mon_cs = eecs;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      check_eq("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("rsp_data", rsp_data, mon_e.data);
        check_eq("rsp_err", rsp_err, mon_e.err);
        if (mon_e.poll_mode) begin
          check_eq("poll_len", cs_fall_cyc - cs_rise_cyc, mon_e.val);
          check_eq("cs_low_before_rsp", cyc - cs_fall_cyc, 2 * C);
        end else begin
          check_eq("rsp_latency", cyc - acc_cyc, mon_e.val);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                       input bit push, input logic [15:0] exp_data, input logic exp_err,
                       input bit poll_mode, input int val);
    int   start;
    exp_t e;
    if (push) begin
      e.data = exp_data;
      e.err = exp_err;
      e.poll_mode = poll_mode;
      e.val = val;
      sb.push_back(e);
    end
    @(negedge clk);
    start     = n_acc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    for (int i = 0; i < 50 && n_acc == start; i++) @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("accept", n_acc - start, 1);
    check_eq("busy_ready_after_accept", {busy, cmd_ready}, 2'b10);
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    check_eq("rsp_arrived", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int start;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 7);
    mem[8'h05] = 16'hA55A;
    mem[8'h10] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", cmd_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_serial", {eecs, eesk, eedi}, 3'b000);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_err", rsp_err, 0);
    check_eq("reset_rsp_data", rsp_data, 16'h0000);

    // READ 0x05: 27 SK pulses, DI = 1,10,00000101 then zeros; valid at 1+2*27*4+8.
    issue(2'd0, 8'h05, 16'h0, 1, 16'hA55A, 1'b0, 0, 225);
    wait_done(400);
    check_eq("read_sk_pulses", frm_sk, 27);
    check_eq("read_di", frm_bits, 64'h0605_0000);

    // EWEN: 11 pulses, DI = 1,00,11000000; rsp_data untouched.
    issue(2'd2, 8'h3C, 16'h0, 1, 16'hA55A, 1'b0, 0, 97);
    wait_done(200);
    check_eq("ewen_sk_pulses", frm_sk, 11);
    check_eq("ewen_di", frm_bits, 64'h04C0);

    // WRITE 0x10: eedo held 0 for 300 poll cycles; the first SK-period
    // sample that sees the 1 is 304 cycles into POLL.
    poll_delay = 300;
    issue(2'd1, 8'h10, 16'h1234, 1, 16'hA55A, 1'b0, 1, 304);
    wait_done(1000);
    check_eq("write_sk_pulses", frm_sk, 27);
    check_eq("write_di", frm_bits, 64'h0510_1234);
    check_eq("write_mem", mem[8'h10], 16'h1234);

    issue(2'd0, 8'h10, 16'h0, 1, 16'h1234, 1'b0, 0, 225);
    wait_done(400);

    // WRITE timeout: eedo stuck 0, POLL lasts exactly PTO cycles.
    poll_delay = 1 << 30;
    issue(2'd1, 8'h20, 16'hBEEF, 1, 16'h1234, 1'b1, 1, PTO);
    wait_done(1200);
    poll_delay = 300;

    // Dummy bit forced high: error flagged, data still captured.
    dummy_val = 1'b1;
    issue(2'd0, 8'h05, 16'h0, 1, 16'hA55A, 1'b1, 0, 225);
    wait_done(400);
    dummy_val = 1'b0;

    // Reset in the middle of a READ: frame abandoned, no response.
    base = rsp_cnt;
    issue(2'd0, 8'h05, 16'h0, 0, 16'h0, 1'b0, 0, 0);
    while (cyc - acc_cyc < 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_cs_sk", {eecs, eesk}, 2'b00);
    check_eq("abort_ready", cmd_ready, 1);
    check_eq("abort_rsp_data", rsp_data, 16'h0000);
    repeat (300) @(negedge clk);
    check_eq("abort_no_rsp", rsp_cnt - base, 0);

    // Back-to-back READs with cmd_valid held high.
    sb.push_back('{data: 16'hA55A, err: 1'b0, poll_mode: 1'b0, val: 225});
    sb.push_back('{data: 16'h1234, err: 1'b0, poll_mode: 1'b0, val: 225});
    @(negedge clk);
    start     = n_acc;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 8'h05;
    for (int i = 0; i < 10 && n_acc == start; i++) @(negedge clk);
    cmd_addr = 8'h10;
    for (int i = 0; i < 400 && n_acc == start + 1; i++) @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("b2b_accepts", n_acc - start, 2);
    check_eq("b2b_accept_after_rsp", acc_cyc - rsp_cyc, 1);
    wait_done(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
